// File: rtl/countdown_timer.sv
// countdown_timer: minutes:seconds countdown with load, start/pause control,
// a one-second prescaler and an expiry flag. All outputs come straight from
// flops so the downstream binary-to-BCD converters see clean, bounded values.
module countdown_timer #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Load,
    input  logic [6:0] LoadMinutes,
    input  logic [6:0] LoadSeconds,
    input  logic       Start,
    input  logic       Pause,
    output logic [6:0] Minutes,
    output logic [6:0] Seconds,
    output logic       Running,
    output logic       Done,
    output logic       SecTick
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [6:0]    min_q, min_d;
    logic [6:0]    sec_q, sec_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          running_q, running_d;
    logic          done_q, done_d;
    logic          sectick_q, sectick_d;
    logic          tick_s;
    logic          time_zero_s;

    // Saturate a preset value so the display never sees an out-of-range digit pair.
    function automatic logic [6:0] clamp7(input logic [6:0] val, input logic [6:0] max_val);
        clamp7 = (val > max_val) ? max_val : val;
    endfunction

    assign time_zero_s = (min_q == 7'd0) && (sec_q == 7'd0);

    // State and datapath registers, cleared asynchronously by Reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            min_q     <= 7'd0;
            sec_q     <= 7'd0;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            sectick_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            done_q    <= done_d;
            sectick_q <= sectick_d;
        end
    end

    // Next-state and time/prescaler update; Load overrides every other control.
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        presc_d = presc_q;
        tick_s  = 1'b0;
        if (Load) begin
            state_d = S_IDLE;
            min_d   = clamp7(LoadMinutes, 7'd99);
            sec_d   = clamp7(LoadSeconds, 7'd59);
            presc_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        state_d = time_zero_s ? S_DONE : S_RUN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (Pause) begin
                        // Pause freezes the prescaler so the partial second survives.
                        state_d = S_PAUSED;
                    end else if (time_zero_s) begin
                        // Defensive: never decrement below 00:00.
                        state_d = S_DONE;
                    end else if (presc_q == PRESC_MAX) begin
                        presc_d = '0;
                        tick_s  = 1'b1;
                        if (sec_q != 7'd0) begin
                            sec_d = sec_q - 7'd1;
                        end else begin
                            sec_d = 7'd59;
                            min_d = min_q - 7'd1;
                        end
                        if ((min_d == 7'd0) && (sec_d == 7'd0)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_RUN;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                S_PAUSED: begin
                    if (Start) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_PAUSED;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output decode from the next state so the flags land on the same edge as the state.
    always_comb begin
        running_d = (state_d == S_RUN);
        done_d    = (state_d == S_DONE);
        sectick_d = tick_s;
    end

    assign Minutes = min_q;
    assign Seconds = sec_q;
    assign Running = running_q;
    assign Done    = done_q;
    assign SecTick = sectick_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICK_DIV=4. Inputs change on the
// falling edge, outputs are sampled on the falling edge.
module tb_countdown_timer;

    logic       clk_s = 1'b0;
    logic       reset_s;
    logic       load_s;
    logic [6:0] load_min_s;
    logic [6:0] load_sec_s;
    logic       start_s;
    logic       pause_s;
    logic [6:0] minutes_s;
    logic [6:0] seconds_s;
    logic       running_s;
    logic       done_s;
    logic       sectick_s;

    int checks_r = 0;
    int errors_r = 0;
    int ticks_r  = 0;

    countdown_timer #(.TICK_DIV(4)) dut (
        .Clk         (clk_s),
        .Reset       (reset_s),
        .Load        (load_s),
        .LoadMinutes (load_min_s),
        .LoadSeconds (load_sec_s),
        .Start       (start_s),
        .Pause       (pause_s),
        .Minutes     (minutes_s),
        .Seconds     (seconds_s),
        .Running     (running_s),
        .Done        (done_s),
        .SecTick     (sectick_s)
    );

    // 10 ns clock.
    always #5 clk_s = ~clk_s;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_s);
    endtask

    task automatic do_load(input logic [6:0] m, input logic [6:0] s);
        load_s     = 1'b1;
        load_min_s = m;
        load_sec_s = s;
        @(negedge clk_s);
        load_s     = 1'b0;
    endtask

    task automatic do_start();
        start_s = 1'b1;
        @(negedge clk_s);
        start_s = 1'b0;
    endtask

    task automatic do_pause();
        pause_s = 1'b1;
        @(negedge clk_s);
        pause_s = 1'b0;
    endtask

    task automatic check_time(input string tag, input logic [6:0] m, input logic [6:0] s);
        check({tag, ".min"}, {25'd0, minutes_s}, {25'd0, m});
        check({tag, ".sec"}, {25'd0, seconds_s}, {25'd0, s});
    endtask

    initial begin
        reset_s    = 1'b1;
        load_s     = 1'b0;
        load_min_s = 7'd0;
        load_sec_s = 7'd0;
        start_s    = 1'b0;
        pause_s    = 1'b0;
        cycles(2);
        check_time("rst", 7'd0, 7'd0);
        check("rst.running", {31'd0, running_s}, 32'd0);
        check("rst.done", {31'd0, done_s}, 32'd0);
        check("rst.sectick", {31'd0, sectick_s}, 32'd0);
        reset_s = 1'b0;
        cycles(2);
        check_time("post_rst", 7'd0, 7'd0);

        // 1. Load 01:05, start, run to expiry.
        do_load(7'd1, 7'd5);
        check_time("t1.load", 7'd1, 7'd5);
        check("t1.running_pre", {31'd0, running_s}, 32'd0);
        do_start();
        check("t1.running", {31'd0, running_s}, 32'd1);
        ticks_r = 0;
        for (int i = 1; i <= 260; i++) begin
            @(negedge clk_s);
            if (sectick_s) ticks_r++;
            if (i == 3) check("t1.sec_c3", {25'd0, seconds_s}, 32'd5);
            if (i == 4) begin
                check("t1.sec_c4", {25'd0, seconds_s}, 32'd4);
                check("t1.tick_c4", {31'd0, sectick_s}, 32'd1);
            end
            if (i == 5) check("t1.tick_c5", {31'd0, sectick_s}, 32'd0);
            if (i == 259) begin
                check_time("t1.c259", 7'd0, 7'd1);
                check("t1.done_c259", {31'd0, done_s}, 32'd0);
            end
        end
        check("t1.ticks", ticks_r, 32'd65);
        check_time("t1.end", 7'd0, 7'd0);
        check("t1.done", {31'd0, done_s}, 32'd1);
        check("t1.running_end", {31'd0, running_s}, 32'd0);
        check("t1.final_tick", {31'd0, sectick_s}, 32'd1);
        cycles(5);
        check_time("t1.hold", 7'd0, 7'd0);

        // 2. Borrow from minutes.
        do_load(7'd2, 7'd0);
        check("t2.done_clr", {31'd0, done_s}, 32'd0);
        do_start();
        cycles(4);
        check_time("t2.tick1", 7'd1, 7'd59);
        cycles(4);
        check_time("t2.tick2", 7'd1, 7'd58);

        // 3. Pause keeps the partial second.
        do_load(7'd0, 7'd10);
        do_start();
        cycles(2);
        do_pause();
        check("t3.running", {31'd0, running_s}, 32'd0);
        cycles(20);
        check_time("t3.paused", 7'd0, 7'd10);
        do_start();
        check("t3.resumed", {31'd0, running_s}, 32'd1);
        check_time("t3.r0", 7'd0, 7'd10);
        cycles(1);
        check_time("t3.r1", 7'd0, 7'd10);
        cycles(1);
        check_time("t3.r2", 7'd0, 7'd9);
        check("t3.tick", {31'd0, sectick_s}, 32'd1);

        // 4. Clamp and zero start.
        do_load(7'd120, 7'd75);
        check_time("t4.clamp", 7'd99, 7'd59);
        check("t4.idle", {31'd0, running_s}, 32'd0);
        do_load(7'd0, 7'd0);
        do_start();
        check("t4.zero_done", {31'd0, done_s}, 32'd1);
        check("t4.zero_tick", {31'd0, sectick_s}, 32'd0);
        check("t4.zero_run", {31'd0, running_s}, 32'd0);

        // 5. Priority cases.
        load_s     = 1'b1;
        start_s    = 1'b1;
        load_min_s = 7'd3;
        load_sec_s = 7'd20;
        @(negedge clk_s);
        load_s  = 1'b0;
        start_s = 1'b0;
        check_time("t5.ls", 7'd3, 7'd20);
        check("t5.ls_run", {31'd0, running_s}, 32'd0);
        check("t5.ls_done", {31'd0, done_s}, 32'd0);
        cycles(8);
        check_time("t5.ls_hold", 7'd3, 7'd20);
        do_start();
        start_s = 1'b1;
        pause_s = 1'b1;
        @(negedge clk_s);
        start_s = 1'b0;
        pause_s = 1'b0;
        check("t5.sp_run", {31'd0, running_s}, 32'd0);
        cycles(8);
        check_time("t5.sp_hold", 7'd3, 7'd20);
        do_load(7'd0, 7'd1);
        do_start();
        cycles(4);
        check("t5.done", {31'd0, done_s}, 32'd1);
        do_start();
        check("t5.done_start", {31'd0, done_s}, 32'd1);
        check("t5.done_start_run", {31'd0, running_s}, 32'd0);
        check_time("t5.done_start_t", 7'd0, 7'd0);
        do_load(7'd0, 7'd5);
        check("t5.done_load", {31'd0, done_s}, 32'd0);
        check_time("t5.done_load_t", 7'd0, 7'd5);

        // 6. Asynchronous reset in the middle of a count.
        do_load(7'd0, 7'd40);
        do_start();
        cycles(12);
        check_time("t6.pre", 7'd0, 7'd37);
        check("t6.pre_run", {31'd0, running_s}, 32'd1);
        #2;
        reset_s = 1'b1;
        #1;
        check_time("t6.async", 7'd0, 7'd0);
        check("t6.async_run", {31'd0, running_s}, 32'd0);
        check("t6.async_done", {31'd0, done_s}, 32'd0);
        check("t6.async_tick", {31'd0, sectick_s}, 32'd0);
        @(negedge clk_s);
        reset_s = 1'b0;
        cycles(6);
        check_time("t6.after", 7'd0, 7'd0);
        do_start();
        check("t6.start_done", {31'd0, done_s}, 32'd1);
        check("t6.start_run", {31'd0, running_s}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors_r, checks_r);
        $finish;
    end

endmodule
